// File: rtl/shift_register_piso.sv
// LSB-first parallel-in/serial-out transmitter with Load/Ready handshake, Frame and Done.
// Optional even-parity trailer bit when SHIFT_REGISTER_PISO_PARITY_EN is defined.
module shift_register_piso #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] D,
  input  logic             Load,
  output logic             Ready,
  output logic             Out,
  output logic             Frame,
  output logic             Done
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef SHIFT_REGISTER_PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;
  logic             accept;
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  // Ready is combinational so a load can chain onto the final bit slot without a gap.
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
  assign Ready = !Rst && ((state_q == IDLE) || (state_q == PARITY));
`else
  assign Ready = !Rst && ((state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == LAST)));
`endif

  assign Out   = out_q;
  assign Frame = frame_q;
  assign Done  = done_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      frame_q <= frame_d;
      done_q  <= done_d;
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next state; Out/Frame are derived from the next state so they are registered.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    out_d   = 1'b0;
    frame_d = 1'b0;
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: accept = Load;
      SHIFT: begin
        if (cnt_q == LAST) begin
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
          state_d = PARITY;
`else
          done_d = 1'b1;
          accept = Load;
          if (!Load) state_d = IDLE;
`endif
        end else begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
      PARITY: begin
        done_d = 1'b1;
        accept = Load;
        if (!Load) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (accept) begin
      shreg_d = D;
      cnt_d   = '0;
      state_d = SHIFT;
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
      par_d   = ^D;
`endif
    end

    frame_d = (state_d != IDLE);
    out_d   = (state_d == SHIFT) && shreg_d[0];
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
    if (state_d == PARITY) out_d = par_d;
`endif
  end

endmodule

// File: tb/tb_shift_register_piso.sv
// Bench for shift_register_piso: directed scenarios then random traffic, checked
// cycle by cycle against a bit-queue model of the serial stream.
module tb_shift_register_piso;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             Rst;
  logic [WIDTH-1:0] D;
  logic             Load;
  logic             Ready;
  logic             Out;
  logic             Frame;
  logic             Done;

  int unsigned n_checks;
  int unsigned n_pass;

  // Model: bits still to appear on Out (front = current cycle), words awaiting Done.
  logic             mq[$];
  logic [WIDTH-1:0] wq[$];
  logic             exp_done;
  logic [WIDTH-1:0] sipo;

  shift_register_piso #(.WIDTH(WIDTH)) dut (
    .Clk   (clk),
    .Rst   (Rst),
    .D     (D),
    .Load  (Load),
    .Ready (Ready),
    .Out   (Out),
    .Frame (Frame),
    .Done  (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // One clock: drive inputs, compare outputs to the model, then advance the model.
  task automatic cycle(input logic rst, input logic ld, input logic [WIDTH-1:0] d);
    logic       exp_ready;
    logic       exp_out;
    logic       seen_out;
    logic [WIDTH-1:0] w;
    @(negedge clk);
    Rst  = rst;
    Load = ld;
    D    = d;
    #1;
    exp_ready = !rst && (mq.size() <= 1);
    exp_out   = 1'b0;
    if (mq.size() > 0) exp_out = mq[0];
    check("out",   32'(Out),   32'(exp_out));
    check("frame", 32'(Frame), 32'(mq.size() > 0));
    check("done",  32'(Done),  32'(exp_done));
    check("ready", 32'(Ready), 32'(exp_ready));
`ifndef SHIFT_REGISTER_PISO_PARITY_EN
    if (exp_done && wq.size() > 0) begin
      w = wq.pop_front();
      check("sipo", 32'(sipo), 32'(w));
    end
`endif
    seen_out = Out;
    @(posedge clk);
    sipo = {seen_out, sipo[WIDTH-1:1]};
    if (rst) begin
      mq.delete();
      wq.delete();
      exp_done = 1'b0;
    end else begin
      exp_done = (mq.size() == 1);
      if (mq.size() > 0) void'(mq.pop_front());
      if (ld && exp_ready) begin
        for (int i = 0; i < int'(WIDTH); i++) mq.push_back(d[i]);
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
        mq.push_back(^d);
`endif
        wq.push_back(d);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, WIDTH'(0));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_done = 1'b0;
    sipo     = '0;
    Rst      = 1'b1;
    Load     = 1'b0;
    D        = '0;

    // Reset then idle
    cycle(1'b1, 1'b1, WIDTH'(4'b1111));
    cycle(1'b1, 1'b0, WIDTH'(0));
    idle(2);

    // Single word
    cycle(1'b0, 1'b1, WIDTH'(4'b1011));
    idle(7);

    // Back-to-back frames
    cycle(1'b0, 1'b1, WIDTH'(4'b1011));
    idle(3);
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
    idle(1);
`endif
    cycle(1'b0, 1'b1, WIDTH'(4'b0110));
    idle(7);

    // Load while busy is ignored
    cycle(1'b0, 1'b1, WIDTH'(4'b0001));
    cycle(1'b0, 1'b0, WIDTH'(0));
    cycle(1'b0, 1'b1, WIDTH'(4'b1111));
    idle(6);

    // Reset mid-frame, then a fresh word
    cycle(1'b0, 1'b1, WIDTH'(4'b1010));
    cycle(1'b0, 1'b0, WIDTH'(0));
    cycle(1'b1, 1'b0, WIDTH'(0));
    idle(3);
    cycle(1'b0, 1'b1, WIDTH'(4'b0011));
    idle(7);

    // Parity-relevant word with an even bit count
    cycle(1'b0, 1'b1, WIDTH'(4'b1001));
    idle(7);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0),
            WIDTH'($urandom));
    end
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_register_piso.md
Name: shift_register_PISO

Overview:
- Parallel-in, serial-out transmitter that sits directly upstream of the 4-bit serial-in, parallel-out shift register and drives its serial input.
- Accepts a WIDTH-bit word over a Load/Ready handshake and emits it LSB-first, one bit per clock.
- LSB-first ordering means that after WIDTH shifts the downstream SIPO holds the word in its original bit order (first bit sent lands in Q[0]).
- Frame and Done outputs tell the consumer when the serial stream is valid and when the full word has landed downstream.

Parameters:
- WIDTH, 4: data word width in bits; legal range 2..32.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- D  input  WIDTH  parallel word to transmit; sampled only on an accepted load.
- Load  input  1  load request; accepted when Load=1 and Ready=1 at a rising edge.
- Ready  output  1  block can accept a word this cycle.
- Out  output  1  serial data; connects to downstream In.
- Frame  output  1  high while Out carries a valid data (or parity) bit.
- Done  output  1  one-cycle pulse: the last bit was shifted out on the previous edge.

Behaviour:
- Clocking: single clock Clk. Reset Rst is synchronous, active-high.
- Reset (Rst=1 at an edge):
  - state=IDLE; shift register, bit counter, Out, Frame and Done all cleared to 0.
  - Load is ignored while Rst=1.
  - Ready=0 while Rst=1; Ready=1 from the first cycle after Rst is deasserted.
- States:
  - IDLE: Out=0, Frame=0, Ready=1.
  - SHIFT: Frame=1, Out=shreg[0], counter runs 0..WIDTH-1.
  - PARITY: only when the optional feature is compiled in.
- Counter and shift-register widths are sized from WIDTH with $clog2.
- Load accept (Load=1, Ready=1 at edge): shreg<=D, counter<=0, state<=SHIFT.
  - Latency: the first bit (D[0]) appears on Out in the cycle immediately after the accepting edge.
- SHIFT, each edge: shreg shifts right by one (zero fill) and counter increments.
  - Out in cycle k (k=0..WIDTH-1) equals D[k].
- Last-bit cycle (counter==WIDTH-1):
  - Ready=1.
  - If Load=1: new word captured, state stays SHIFT, counter<=0. Back-to-back frames with no gap; Frame stays high.
  - If Load=0: state<=IDLE.
- Done:
  - Registered; high for exactly one cycle, the cycle after the final bit (final data bit, or parity bit if enabled) was on Out.
  - In that cycle the downstream SIPO holds the complete word.
  - Done may coincide with Frame=1 when frames run back-to-back.
- Ready is combinational: (state==IDLE) or (state==SHIFT and counter==WIDTH-1 and parity disabled) or (state==PARITY), all gated by !Rst.
- Load while Ready=0: ignored, with no effect on D capture, counter or Out.
- D changing mid-frame: no effect; only the value at the accepting edge is used.
- Reset mid-frame:
  - Frame aborts immediately: Out=0, Frame=0 from the next cycle.
  - No Done pulse is issued for the aborted word.
- Out is a registered output, so there are no glitches.

Optional Feature:
- Macro: SHIFT_REGISTER_PISO_PARITY_EN.
- Defined:
  - After the last data bit, FSM enters PARITY for one cycle: Out = even-parity bit (XOR of the captured D), Frame=1.
  - Ready=1 only in the PARITY cycle, not in the last data cycle.
  - A Load during PARITY starts the next frame back-to-back.
  - Done is asserted the cycle after PARITY.
  - Frame length is WIDTH+1 cycles.
- Undefined:
  - No PARITY state; frame length is WIDTH cycles; behaviour is as described above.

Test Plan:
- Reset then idle: Rst=1 for 2 cycles, then 0 -> Out=0, Frame=0, Done=0, Ready=0 during reset; Ready=1 in the first cycle after release.
- Single word, WIDTH=4: D=4'b1011, Load pulse -> Out=1,1,0,1 over the next 4 cycles, Frame=1 for exactly those 4 cycles, Done=1 in cycle 5. Attached SIPO Q=4'b1011 in the Done cycle.
- Back-to-back: load 4'b1011, then hold Load=1 with D=4'b0110 during the last-bit cycle -> Out=1,1,0,1,0,1,1,0 with no gap. Frame high for 8 cycles; Done pulses in cycle 5 and cycle 9.
- Busy load ignored: Load=1, D=4'b1111 in cycle 2 of a 4'b0001 frame -> Out stays 1,0,0,0; Done once; SIPO Q=4'b0001.
- Reset mid-frame: Rst=1 in cycle 2 of a 4'b1010 frame -> next cycle Out=0, Frame=0, no Done pulse. A new load 4'b0011 afterwards transmits correctly.
- Parity (SHIFT_REGISTER_PISO_PARITY_EN): D=4'b1011 -> Out=1,1,0,1,1 with parity=1, Frame 5 cycles, Done in cycle 6. D=4'b1001 -> parity bit 0.
